// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: geometry, wrap-aware pointer and controller state.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;

  typedef struct packed {
    logic                 wrap;
    logic [ROB_IDX_W-1:0] idx;
  } rob_ptr_t;

  typedef enum logic {
    RUN  = 1'b0,
    WALK = 1'b1
  } rob_state_e;

endpackage

// File: rtl/rob_ctrl_if.sv
// Signal bundle between the ROB controller (slave) and the backend/dispatch side (master).
interface rob_ctrl_if
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W
);

  logic               enq_valid;
  logic               enq_ready;
  logic [IDX_W-1:0]   enq_idx;
  logic [1:0]         wb_valid;
  logic [2*IDX_W-1:0] wb_idx;
  logic [DEPTH-1:0]   entry_enq;
  logic [DEPTH-1:0]   entry_wb;
  logic [DEPTH-1:0]   entry_release;
  logic [DEPTH-1:0]   entry_deq;
  logic [1:0]         commit_valid;
  logic [IDX_W-1:0]   commit_idx0;
  logic [IDX_W-1:0]   commit_idx1;
  logic               redirect;
  logic [IDX_W-1:0]   redirect_idx;
  logic               walk_valid;
  logic [IDX_W-1:0]   walk_idx;
  logic               busy;
  logic [IDX_W:0]     count;

  modport master (
    output enq_valid, wb_valid, wb_idx, entry_deq, redirect, redirect_idx,
    input  enq_ready, enq_idx, entry_enq, entry_wb, entry_release,
           commit_valid, commit_idx0, commit_idx1, walk_valid, walk_idx, busy, count
  );

  modport slave (
    input  enq_valid, wb_valid, wb_idx, entry_deq, redirect, redirect_idx,
    output enq_ready, enq_idx, entry_enq, entry_wb, entry_release,
           commit_valid, commit_idx0, commit_idx1, walk_valid, walk_idx, busy, count
  );

endinterface

// File: rtl/rob_ptr.sv
// Wrap-aware ROB pointer: advances by 0..2 and retreats by 0..1 each cycle.
module rob_ptr
  import rob_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic [1:0] inc,
  input  logic     dec,
  output rob_ptr_t ptr
);

  localparam int PTR_W = ROB_IDX_W + 1;

  logic [PTR_W-1:0] ptr_nxt;

  assign ptr_nxt = ptr + PTR_W'(inc) - PTR_W'(dec);

  always_ff @(posedge clock) begin
    if (reset) ptr <= '0;
    else       ptr <= rob_ptr_t'(ptr_nxt);
  end

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer head/tail controller: in-order allocate, dual in-order commit,
// and a one-slot-per-cycle tail walk after a redirect so rename can roll back.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W
) (
  input  logic      clock,
  input  logic      reset,
  rob_ctrl_if.slave rob
);

  localparam int PTR_W = IDX_W + 1;

  rob_state_e       state, state_nxt;
  rob_ptr_t         head, tail;
  logic [IDX_W-1:0] keep_q;
  logic [PTR_W-1:0] occ;
  logic             full, empty;
  logic [IDX_W-1:0] head_p1, tail_m1, tail_m2, rd_off;
  logic [IDX_W-1:0] keep_idx, flush_n;
  logic             redir_ok, commit0, commit1, enq_rdy, enq_fire;
  logic             walk_act, flush_act;
  logic [1:0]       head_inc;
  logic [DEPTH-1:0] flush_mask, wb_hit, enq_vec, rel_vec;

  function automatic logic [DEPTH-1:0] onehot(input logic [IDX_W-1:0] slot);
    return DEPTH'(1) << slot;
  endfunction

  // A slot is being flushed when it lies strictly after keep and no further than span past it.
  function automatic logic in_flush(input logic [IDX_W-1:0] slot,
                                    input logic [IDX_W-1:0] keep,
                                    input logic [IDX_W-1:0] span);
    logic [IDX_W-1:0] off;
    off = slot - keep;
    return (off != '0) && (off <= span);
  endfunction

  assign occ     = PTR_W'(tail - head);
  assign full    = (tail.wrap != head.wrap) && (tail.idx == head.idx);
  assign empty   = (tail == head);
  assign head_p1 = head.idx + IDX_W'(1);
  assign tail_m1 = tail.idx - IDX_W'(1);
  assign tail_m2 = tail.idx - IDX_W'(2);
  assign rd_off  = rob.redirect_idx - head.idx;

  // Redirects pointing outside [head, tail-1] are dropped.
  assign redir_ok = (state == RUN) && rob.redirect && !empty && (PTR_W'(rd_off) < occ);

  assign head_inc = {1'b0, commit0} + {1'b0, commit1};

  rob_ptr u_head (
    .clock (clock),
    .reset (reset),
    .inc   (head_inc),
    .dec   (1'b0),
    .ptr   (head)
  );

  rob_ptr u_tail (
    .clock (clock),
    .reset (reset),
    .inc   ({1'b0, enq_fire}),
    .dec   (walk_act),
    .ptr   (tail)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset)         keep_q <= '0;
    else if (redir_ok) keep_q <= rob.redirect_idx;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (redir_ok && (tail_m1 != rob.redirect_idx)) state_nxt = WALK;
      WALK:    if (tail_m2 == keep_q) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    walk_act  = (state == WALK) && !reset;
    commit0   = (state == RUN) && !redir_ok && !empty && rob.entry_deq[head.idx];
    commit1   = commit0 && (occ >= PTR_W'(2)) && rob.entry_deq[head_p1];
    // A full ROB still accepts an enq when the head retires in the same cycle.
    enq_rdy   = (state == RUN) && !redir_ok && (!full || commit0);
    enq_fire  = rob.enq_valid && enq_rdy;
    flush_act = (state == WALK) || redir_ok;
    keep_idx  = (state == WALK) ? keep_q : rob.redirect_idx;
    flush_n   = tail_m1 - keep_idx;

    flush_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      flush_mask[i] = flush_act && in_flush(IDX_W'(i), keep_idx, flush_n);
    end

    wb_hit = '0;
    for (int p = 0; p < 2; p++) begin
      if (rob.wb_valid[p]) wb_hit = wb_hit | onehot(rob.wb_idx[p*IDX_W +: IDX_W]);
    end

    enq_vec = enq_fire ? onehot(tail.idx) : '0;

    rel_vec = '0;
    if (commit0) rel_vec = rel_vec | onehot(head.idx);
    if (commit1) rel_vec = rel_vec | onehot(head_p1);
    // The slot reallocated this cycle must not see a competing clear.
    rel_vec = rel_vec & ~enq_vec;
    if (walk_act) rel_vec = rel_vec | onehot(tail_m1);

    rob.enq_ready     = enq_rdy;
    rob.enq_idx       = tail.idx;
    rob.entry_enq     = enq_vec;
    rob.entry_wb      = wb_hit & ~flush_mask;
    rob.entry_release = rel_vec;
    rob.commit_valid  = {commit1, commit0};
    rob.commit_idx0   = commit0 ? head.idx : '0;
    rob.commit_idx1   = commit1 ? head_p1 : '0;
    rob.walk_valid    = walk_act;
    rob.walk_idx      = walk_act ? tail_m1 : '0;
    rob.busy          = (state == WALK);
    rob.count         = occ;
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed + random bench for rob_ctrl against an absolute-sequence-number ROB model.
module tb_rob_ctrl;
  import rob_pkg::*;

  localparam int D = ROB_DEPTH;
  localparam int W = ROB_IDX_W;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rob_ctrl_if #(.DEPTH(D), .IDX_W(W)) rob ();

  rob_ctrl #(.DEPTH(D), .IDX_W(W)) dut (
    .clock (clock),
    .reset (reset),
    .rob   (rob)
  );

  int checks = 0;
  int errors = 0;

  // Model: h/t are unbounded sequence numbers of oldest and next instruction.
  int h = 0, t = 0, keep = 0;
  bit walking = 0, model_ok = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset            = 1'b0;
    rob.enq_valid    = 1'b0;
    rob.wb_valid     = 2'b00;
    rob.wb_idx       = '0;
    rob.entry_deq    = '0;
    rob.redirect     = 1'b0;
    rob.redirect_idx = '0;
  endtask

  // Inputs are already driven; check all outputs against the model, advance it, wait one cycle.
  task automatic step();
    int cnt, off, keepc;
    bit racc, c0, c1, rdy, fire, wv;
    logic [D-1:0] e_enq, e_wb, e_rel, flush;
    #1;
    cnt = t - h;
    racc = 0; c0 = 0; c1 = 0; rdy = 0; wv = 0; flush = '0; keepc = keep;
    if (!walking) begin
      off   = (int'(rob.redirect_idx) - (h % D) + D) % D;
      racc  = rob.redirect && (cnt > 0) && (off < cnt);
      keepc = h + off;
      c0    = !racc && (cnt >= 1) && rob.entry_deq[h % D];
      c1    = c0 && (cnt >= 2) && rob.entry_deq[(h + 1) % D];
      rdy   = !racc && ((cnt < D) || c0);
      if (racc) for (int a = keepc + 1; a < t; a++) flush[a % D] = 1'b1;
    end else begin
      wv = !reset;
      for (int a = keep + 1; a < t; a++) flush[a % D] = 1'b1;
    end
    fire  = rob.enq_valid && rdy;
    e_enq = '0;
    if (fire) e_enq[t % D] = 1'b1;
    e_rel = '0;
    if (c0) e_rel[h % D] = 1'b1;
    if (c1) e_rel[(h + 1) % D] = 1'b1;
    e_rel = e_rel & ~e_enq;
    if (wv) e_rel[(t - 1) % D] = 1'b1;
    e_wb = '0;
    if (rob.wb_valid[0]) e_wb[rob.wb_idx[W-1:0]] = 1'b1;
    if (rob.wb_valid[1]) e_wb[rob.wb_idx[2*W-1:W]] = 1'b1;
    e_wb = e_wb & ~flush;

    if (model_ok) begin
      check("enq_ready",     32'(rob.enq_ready),     32'(rdy));
      check("enq_idx",       32'(rob.enq_idx),       t % D);
      check("entry_enq",     32'(rob.entry_enq),     32'(e_enq));
      check("entry_wb",      32'(rob.entry_wb),      32'(e_wb));
      check("entry_release", 32'(rob.entry_release), 32'(e_rel));
      check("commit_valid",  32'(rob.commit_valid),  32'({c1, c0}));
      check("commit_idx0",   32'(rob.commit_idx0),   c0 ? (h % D) : 0);
      check("commit_idx1",   32'(rob.commit_idx1),   c1 ? ((h + 1) % D) : 0);
      check("walk_valid",    32'(rob.walk_valid),    32'(wv));
      check("walk_idx",      32'(rob.walk_idx),      wv ? ((t - 1) % D) : 0);
      check("busy",          32'(rob.busy),          32'(walking));
      check("count",         32'(rob.count),         cnt);
    end

    if (reset) begin
      h = 0; t = 0; walking = 0; model_ok = 1;
    end else if (walking) begin
      t--;
      if (t - 1 == keep) walking = 0;
    end else if (racc) begin
      if (keepc != t - 1) begin
        walking = 1;
        keep    = keepc;
      end
    end else begin
      h += int'(c0) + int'(c1);
      t += int'(fire);
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    @(negedge clock);
    do_reset();
    step();

    // Fill sixteen slots, then one refused enq.
    rob.enq_valid = 1'b1;
    repeat (16) step();
    check("fill_count", 32'(rob.count), 16);
    check("fill_ready", 32'(rob.enq_ready), 0);
    step();

    // Slots 0,1 complete together, slot 2 the next cycle; head lands on 3.
    rob.enq_valid = 1'b0;
    rob.entry_deq = 16'h0003;
    step();
    rob.entry_deq = 16'h0004;
    step();
    check("commit3_count", 32'(rob.count), 13);
    rob.entry_deq = 16'h0008;
    #1;
    check("head3", 32'(rob.commit_idx0), 3);
    step();
    rob.entry_deq = '1;
    repeat (8) step();

    // Move head/tail to 14, then enqueue across the wrap.
    rob.enq_valid = 1'b1;
    repeat (14) step();
    rob.enq_valid = 1'b0;
    repeat (10) step();
    rob.entry_deq = '0;
    rob.enq_valid = 1'b1;
    repeat (4) step();
    check("wrap_count", 32'(rob.count), 4);
    rob.enq_valid = 1'b0;

    // Enq while full and the head commits.
    do_reset();
    rob.enq_valid = 1'b1;
    repeat (16) step();
    rob.entry_deq = 16'h0001;
    step();
    check("full_enq_commit", 32'(rob.count), 16);

    // Walk from tail 10 back to keep 6.
    do_reset();
    rob.enq_valid = 1'b1;
    repeat (10) step();
    rob.enq_valid    = 1'b0;
    rob.redirect     = 1'b1;
    rob.redirect_idx = 4'd6;
    step();
    rob.redirect = 1'b0;
    check("walk_busy", 32'(rob.busy), 1);
    repeat (3) step();
    check("walk_done_busy", 32'(rob.busy), 0);
    check("walk_done_count", 32'(rob.count), 7);
    rob.enq_valid = 1'b1;
    #1;
    check("walk_enq_idx", 32'(rob.enq_idx), 7);
    step();
    rob.enq_valid = 1'b0;

    // Redirect at the youngest slot: nothing to flush.
    rob.redirect     = 1'b1;
    rob.redirect_idx = 4'd7;
    step();
    rob.redirect = 1'b0;
    check("noflush_busy", 32'(rob.busy), 0);

    // Reset during the second walk cycle.
    rob.redirect     = 1'b1;
    rob.redirect_idx = 4'd2;
    step();
    rob.redirect = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstwalk_count", 32'(rob.count), 0);
    check("rstwalk_walk", 32'(rob.walk_valid), 0);
    check("rstwalk_busy", 32'(rob.busy), 0);
    check("rstwalk_enq_idx", 32'(rob.enq_idx), 0);

    // Random traffic.
    repeat (2000) begin
      reset          = ($urandom_range(0, 299) == 0);
      rob.enq_valid  = ($urandom_range(0, 3) != 0);
      rob.wb_valid   = 2'($urandom);
      rob.wb_idx     = (2*W)'($urandom);
      rob.entry_deq  = D'($urandom);
      rob.redirect   = ($urandom_range(0, 11) == 0);
      if ((t - h) > 0 && $urandom_range(0, 3) != 0)
        rob.redirect_idx = W'((h + $urandom_range(0, t - h - 1)) % D);
      else
        rob.redirect_idx = W'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
